// File: rtl/interrupt_controller.sv
// interrupt_controller: 8-source edge-triggered interrupt controller with fixed priority (0 highest).
// Single in-service slot; EOI write frees it. Registers at BASE_ADDR..BASE_ADDR+3.
module interrupt_controller #(
    parameter logic [15:0] BASE_ADDR = 16'h10F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq_src,
    input  logic [15:0] io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [7:0]  io_rdata,
    output logic        irq,
    input  logic        irq_ack
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [7:0]  pending_q, pending_d, mask_q, mask_d, rdata_q, rdata_d;
    logic [2:0]  idx_q, idx_d, top_idx;
    logic [15:0] off;
    logic        hit, wr_pend, wr_mask, wr_eoi, ack_take, eoi;
    logic [7:0]  rise, qual, clr, active;

    always_comb begin
        off     = io_addr - BASE_ADDR;
        hit     = off[15:2] == 14'd0;
        wr_pend = io_we && hit && off[1:0] == 2'd0;
        wr_mask = io_we && hit && off[1:0] == 2'd1;
        wr_eoi  = io_we && hit && off[1:0] == 2'd3;
    end

    always_comb begin
        top_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (qual[i]) top_idx = 3'(i);
    end

    // Clears are applied before new edges are OR'd in, so a fresh edge always survives.
    always_comb begin
        sync1_d   = irq_src;
        sync2_d   = sync1_q;
        hist_d    = sync2_q;
        rise      = sync2_q & ~hist_q;
        qual      = pending_q & mask_q;
        ack_take  = state_q == IDLE && irq_ack && |qual;
        eoi       = state_q == BUSY && wr_eoi;
        clr       = (wr_pend ? io_wdata : 8'h00) | (ack_take ? 8'h01 << top_idx : 8'h00);
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = wr_mask ? io_wdata : mask_q;
        idx_d     = ack_take ? top_idx : eoi ? 3'd0 : idx_q;
        active    = {state_q == BUSY, 4'b0000, idx_q};
        rdata_d   = !(io_re && hit) ? 8'h00 :
                    off[1:0] == 2'd0 ? pending_q :
                    off[1:0] == 2'd1 ? mask_q :
                    off[1:0] == 2'd2 ? active : 8'h00;
    end

    always_comb begin
        state_d = state_q == IDLE ? (ack_take ? BUSY : IDLE) : (eoi ? IDLE : BUSY);
    end

    always_comb begin
        irq      = state_q == IDLE && |qual;
        io_rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            idx_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h10F0, giving the I/O address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port irq_src  input  8  raw interrupt sources, asynchronous to clk, rising-edge triggered.
REQ-005 SHALL have port io_addr  input  16  CPU data/I-O address.
REQ-006 SHALL have port io_wdata  input  8  CPU write data.
REQ-007 SHALL have port io_we  input  1  CPU write strobe, one cycle per write.
REQ-008 SHALL have port io_re  input  1  CPU read strobe.
REQ-009 SHALL have port io_rdata  output  8  registered read data, OR-able onto the CPU read bus.
REQ-010 SHALL have port irq  output  1  interrupt request to the CPU interrupt_0 input.
REQ-011 SHALL have port irq_ack  input  1  one-cycle acknowledge from the CPU interrupt_0_clr output.

Function
REQ-012 SHALL pass each irq_src bit through a 2-flop synchronizer followed by a history flop; a sync-output 0->1 transition sets that bit of PENDING.
REQ-013 SHALL set a PENDING bit on the 3rd rising clk edge after the first edge that samples irq_src high; pulses shorter than one clk period need not be captured.
REQ-014 SHALL map: BASE+0 PENDING (read; write-1-to-clear); BASE+1 MASK (read/write, 1 = enabled); BASE+2 ACTIVE (read-only: bit7 = in-service valid, bits2:0 = in-service source index, bits6:3 = 0); BASE+3 EOI (write any value: clears in-service; reads 0).
REQ-015 SHALL update registers on the clk edge where io_we is high and io_addr matches; non-matching writes SHALL have no effect.
REQ-016 SHALL present io_rdata one cycle after an io_re with matching io_addr; all other cycles io_rdata SHALL be 8'h00.
REQ-017 SHALL treat source 0 as highest priority and source 7 as lowest.
REQ-018 SHALL hold two states: IDLE (no in-service) and BUSY (in-service valid).
REQ-019 SHALL drive irq = 1 only in IDLE when (PENDING & MASK) != 0; irq SHALL be decoded only from flops.
REQ-020 SHALL, on irq_ack in IDLE with qualified pending: latch the highest-priority qualified index into ACTIVE, clear that PENDING bit, and enter BUSY on the same edge.
REQ-021 SHALL ignore irq_ack in BUSY or when no qualified pending bit exists.
REQ-022 SHALL, on an EOI write in BUSY, return to IDLE on that edge; irq re-asserts the next cycle if qualified pending remains.
REQ-023 SHALL continue latching edges into PENDING while in BUSY, including for the in-service source.
REQ-024 SHALL, on simultaneous new edge and W1C clear of the same bit, leave the bit set (set wins).
REQ-025 SHALL, on simultaneous new edge and irq_ack clear of the same bit, leave the bit set.
REQ-026 SHALL NOT alter PENDING on MASK writes; masked bits stay pending and are not reported via irq.

Reset
REQ-027 SHALL, while rst_n = 0, force PENDING = 0, MASK = 0, state IDLE, ACTIVE = 8'h00, io_rdata = 0, irq = 0, and all synchronizer and history flops = 0, immediately and independent of clk.
REQ-028 SHALL, if irq_src bit is high at rst_n release, register it as a rising edge and set PENDING per REQ-013.
REQ-029 SHALL abandon any in-service interrupt on reset mid-operation; no state is retained.

Verification
REQ-030 SHALL cover: MASK=8'h04, irq_src[2] 0->1 -> PENDING=8'h04 after 3 edges, irq=1; irq_ack -> irq=0, ACTIVE=8'h82, PENDING=8'h00.
REQ-031 SHALL cover: MASK=8'hFF, sources 5 and 1 rise together -> ack latches ACTIVE=8'h81; EOI write -> irq=1 next cycle; second ack -> ACTIVE=8'h85.
REQ-032 SHALL cover: MASK=8'h00, source 3 rises -> PENDING=8'h08, irq=0; write MASK=8'h08 -> irq=1; write 8'h08 to BASE+0 -> PENDING=0, irq=0.
REQ-033 SHALL cover: source 0 edge landing on the same edge as W1C of bit 0 -> PENDING[0]=1 afterward.
REQ-034 SHALL cover: BUSY on source 4, new edge on source 4 -> PENDING=8'h10, irq=0 until EOI, then irq=1.
REQ-035 SHALL cover: rst_n low mid-BUSY with irq_src[6] held high -> all outputs 0 immediately; after release PENDING=8'h40 at 3rd edge, irq=0 (MASK=0).
